vend_fsm_param: RTL and testbench

Parametrised coin-operated vending controller: single product, configurable price and coin values, binary credit register in place of one-state-per-credit encoding. Accepts three coin types, vends once credit reaches PRICE, then pays out change one coin per cycle (greedy, high coin first) under dispenser back-pressure. Supports a refund request and rejects invalid or out-of-state coins. Sits between the coin acceptor front-end and the product/coin dispenser actuators.

---
 rtl/vend_fsm_param_if.sv | 26 ++
 rtl/vend_fsm_param.sv | 100 ++++++++++
 tb/tb_vend_fsm_param.sv | 129 ++++++++++++
 3 files changed

// File: rtl/vend_fsm_param_if.sv
// Coin acceptor / dispenser bundle between the front-end and the vending controller.
interface vend_fsm_param_if #(
  parameter int CREDIT_W = 5
);
  logic                i1;
  logic                i5;
  logic                i10;
  logic                rest;
  logic                disp_rdy;
  logic                suc;
  logic                r1;
  logic                r5;
  logic                coin_rej;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport master (
    output i1, i5, i10, rest, disp_rdy,
    input  suc, r1, r5, coin_rej, credit, busy
  );

  modport slave (
    input  i1, i5, i10, rest, disp_rdy,
    output suc, r1, r5, coin_rej, credit, busy
  );
endinterface

// File: rtl/vend_fsm_param.sv
// Single-product vending controller with binary credit; vends at PRICE, then pays change
// greedily (VAL_B coins first, then 1-unit) one coin per cycle, stalling while disp_rdy is low.
module vend_fsm_param #(
  parameter int PRICE    = 3,
  parameter int VAL_B    = 5,
  parameter int VAL_C    = 10,
  parameter int CREDIT_W = 5
) (
  input logic            clk,
  input logic            reset,
  vend_fsm_param_if.slave bus
);

  typedef enum logic [1:0] {COLLECT, VEND, PAYOUT} state_t;

  localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0]   VB_X    = (CREDIT_W+1)'(VAL_B);
  localparam logic [CREDIT_W:0]   VC_X    = (CREDIT_W+1)'(VAL_C);
  localparam logic [CREDIT_W-1:0] PRICE_W = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] VB_W    = CREDIT_W'(VAL_B);
  localparam logic [CREDIT_W-1:0] ONE_W   = CREDIT_W'(1);

  state_t              state;
  logic [CREDIT_W-1:0] credit;
  logic                rej_q;

  logic [1:0]          ncoins;
  logic                any_coin;
  logic                valid;
  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] remain;
  logic                pay_b;
  logic                pay;
  logic [CREDIT_W-1:0] after_pay;

  assign ncoins   = {1'b0, bus.i1} + {1'b0, bus.i5} + {1'b0, bus.i10};
  assign any_coin = bus.i1 | bus.i5 | bus.i10;
  assign valid    = (ncoins == 2'd1);

  always_comb begin
    coin_val = '0;
    if (bus.i1)
      coin_val = (CREDIT_W+1)'(1);
    else if (bus.i5)
      coin_val = VB_X;
    else if (bus.i10)
      coin_val = VC_X;
  end

  // Sum is one bit wider so the PRICE comparison cannot wrap.
  assign sum       = {1'b0, credit} + coin_val;
  assign remain    = credit - PRICE_W;
  assign pay_b     = (credit >= VB_W);
  assign pay       = (state == PAYOUT) && bus.disp_rdy && (credit != '0);
  assign after_pay = credit - (pay_b ? VB_W : ONE_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= COLLECT;
      credit <= '0;
      rej_q  <= 1'b0;
    end else begin
      rej_q <= any_coin && ((state != COLLECT) || !valid);
      case (state)
        COLLECT: begin
          if (any_coin) begin
            if (valid) begin
              credit <= sum[CREDIT_W-1:0];
              if (sum >= PRICE_X)
                state <= VEND;
            end
          end else if (bus.rest && (credit != '0)) begin
            state <= PAYOUT;
          end
        end
        VEND: begin
          credit <= remain;
          state  <= (remain != '0) ? PAYOUT : COLLECT;
        end
        PAYOUT: begin
          if (pay) begin
            credit <= after_pay;
            if (after_pay == '0)
              state <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.suc      = (state == VEND);
  assign bus.r5       = pay && pay_b;
  assign bus.r1       = pay && !pay_b;
  assign bus.coin_rej = rej_q;
  assign bus.credit   = credit;
  assign bus.busy     = (state != COLLECT);

endmodule

// File: tb/tb_vend_fsm_param.sv
// Directed bench for vend_fsm_param with PRICE=3, VAL_B=5, VAL_C=10.
module tb_vend_fsm_param;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  vend_fsm_param_if #(.CREDIT_W(5)) bus ();

  vend_fsm_param #(
    .PRICE(3), .VAL_B(5), .VAL_C(10), .CREDIT_W(5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock, then settle just past the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input int suc, input int r1, input int r5,
                      input int rej, input int cr, input int busy);
    #1;
    check({tag, ".suc"},    32'(bus.suc),      32'(suc));
    check({tag, ".r1"},     32'(bus.r1),       32'(r1));
    check({tag, ".r5"},     32'(bus.r5),       32'(r5));
    check({tag, ".rej"},    32'(bus.coin_rej), 32'(rej));
    check({tag, ".credit"}, 32'(bus.credit),   32'(cr));
    check({tag, ".busy"},   32'(bus.busy),     32'(busy));
  endtask

  task automatic coin(input int kind);
    bus.i1  = (kind == 1);
    bus.i5  = (kind == 5);
    bus.i10 = (kind == 10);
    cyc();
    bus.i1  = 1'b0;
    bus.i5  = 1'b0;
    bus.i10 = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.i1 = 1'b0; bus.i5 = 1'b0; bus.i10 = 1'b0;
    bus.rest = 1'b0; bus.disp_rdy = 1'b1;
    reset = 1'b1;
    #2;
    outs("reset", 0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    reset = 1'b0;

    // three 1-unit coins reach the price exactly
    coin(1);  outs("t1.c1", 0, 0, 0, 0, 1, 0);
    coin(1);  outs("t1.c2", 0, 0, 0, 0, 2, 0);
    coin(1);  outs("t1.vend", 1, 0, 0, 0, 3, 1);
    cyc();    outs("t1.done", 0, 0, 0, 0, 0, 0);

    // 10 in: vend then 7 = 5+1+1
    coin(10); outs("t2.vend", 1, 0, 0, 0, 10, 1);
    cyc();    outs("t2.p5", 0, 0, 1, 0, 7, 1);
    cyc();    outs("t2.p1a", 0, 1, 0, 0, 2, 1);
    cyc();    outs("t2.p1b", 0, 1, 0, 0, 1, 1);
    cyc();    outs("t2.done", 0, 0, 0, 0, 0, 0);

    // refund with zero credit is ignored
    bus.rest = 1'b1;
    cyc();    outs("t3.rest0", 0, 0, 0, 0, 0, 0);
    bus.rest = 1'b0;

    // refund of one unit
    coin(1);  outs("t3.c1", 0, 0, 0, 0, 1, 0);
    bus.rest = 1'b1;
    cyc();
    bus.rest = 1'b0;
    outs("t3.r1", 0, 1, 0, 0, 1, 1);
    cyc();    outs("t3.done", 0, 0, 0, 0, 0, 0);

    // 5 in with dispenser stalled
    bus.disp_rdy = 1'b0;
    coin(5);  outs("t4.vend", 1, 0, 0, 0, 5, 1);
    for (int k = 0; k < 4; k++) begin
      cyc();  outs($sformatf("t4.stall%0d", k), 0, 0, 0, 0, 2, 1);
    end
    coin(1);  outs("t4.rej", 0, 0, 0, 1, 2, 1);
    cyc();    outs("t4.rejclr", 0, 0, 0, 0, 2, 1);
    bus.disp_rdy = 1'b1;
    outs("t4.p1a", 0, 1, 0, 0, 2, 1);
    cyc();    outs("t4.p1b", 0, 1, 0, 0, 1, 1);
    cyc();    outs("t4.done", 0, 0, 0, 0, 0, 0);

    // two coins at once are invalid
    bus.i1 = 1'b1; bus.i5 = 1'b1;
    cyc();
    bus.i1 = 1'b0; bus.i5 = 1'b0;
    outs("t5.rej", 0, 0, 0, 1, 0, 0);
    cyc();    outs("t5.clr", 0, 0, 0, 0, 0, 0);

    // reset in the middle of payout
    coin(10); outs("t6.vend", 1, 0, 0, 0, 10, 1);
    cyc();    outs("t6.p5", 0, 0, 1, 0, 7, 1);
    cyc();    outs("t6.p1", 0, 1, 0, 0, 2, 1);
    reset = 1'b1;
    outs("t6.rst", 0, 0, 0, 0, 0, 0);
    cyc();
    reset = 1'b0;
    coin(1);  outs("t6.c1", 0, 0, 0, 0, 1, 0);
    coin(1);  outs("t6.c2", 0, 0, 0, 0, 2, 0);
    coin(1);  outs("t6.vend2", 1, 0, 0, 0, 3, 1);
    cyc();    outs("t6.done", 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
